rvfi_generator: RTL and testbench

- Synthesizable producer of the RISC-V Formal Interface (RVFI) retirement trace for the RS5 core.
- Sits beside the writeback stage. Takes one retirement record per accepted instruction and, for loads, merges the late LSU response.
- Drives a registered, in-order RVFI bus with a monotonically increasing rvfi_order, for the simulation monitor, tracer, profiler and checker to consume.

---
 rtl/rvfi_monitor_pkg.sv | 25 ++
 rtl/rvfi_load_watchdog.sv | 24 ++
 rtl/rvfi_generator.sv | 150 +++++++++++++++
 tb/tb_rvfi_generator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_monitor_pkg.sv
// rvfi_monitor_pkg: shared types for the RVFI retirement generator
package rvfi_monitor_pkg;
    localparam logic [1:0] RVFI_IXL_RV32 = 2'b01;

    typedef enum logic {IDLE, WAIT_LOAD} rvfi_gen_state_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        trap;
        logic        halt;
        logic        irq_taken;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
    } ret_record_t;
endpackage

// File: rtl/rvfi_load_watchdog.sv
// rvfi_load_watchdog: counts load-wait cycles, raises a sticky timeout flag
module rvfi_load_watchdog #(
    parameter int CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    output logic err
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= start ? '0 : (active && !err) ? cnt + W'(1) : cnt;
            if (active && cnt == W'(CYCLES - 1)) err <= 1'b1;
        end
    end
endmodule

// File: rtl/rvfi_generator.sv
// rvfi_generator: registered in-order RVFI trace with late load-data merge
// Optional load watchdog enabled by defining RVFI_GEN_WATCHDOG_EN.
module rvfi_generator
    import rvfi_monitor_pkg::*;
#(
    parameter int         ORDER_WIDTH     = 64,
    parameter logic [1:0] PRIV_MODE       = 2'b11,
    parameter int         WATCHDOG_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ret_valid,
    output logic        ret_ready,
    input  logic [31:0] ret_insn,
    input  logic [31:0] ret_pc,
    input  logic [31:0] ret_next_pc,
    input  logic        ret_trap,
    input  logic        ret_halt,
    input  logic        ret_irq_taken,
    input  logic [4:0]  ret_rs1_addr,
    input  logic [4:0]  ret_rs2_addr,
    input  logic [4:0]  ret_rd_addr,
    input  logic [31:0] ret_rs1_rdata,
    input  logic [31:0] ret_rs2_rdata,
    input  logic [31:0] ret_rd_wdata,
    input  logic        ret_is_load,
    input  logic [31:0] ret_mem_addr,
    input  logic [31:0] ret_mem_wdata,
    input  logic [3:0]  ret_mem_rmask,
    input  logic [3:0]  ret_mem_wmask,
    input  logic        lsu_rvalid,
    input  logic [31:0] lsu_rdata,
    input  logic [31:0] lsu_rd_wdata,
    output logic        rvfi_valid,
    output logic [63:0] rvfi_order,
    output logic [31:0] rvfi_insn,
    output logic        rvfi_trap,
    output logic        rvfi_halt,
    output logic        rvfi_intr,
    output logic [1:0]  rvfi_mode,
    output logic [1:0]  rvfi_ixl,
    output logic [4:0]  rvfi_rs1_addr,
    output logic [4:0]  rvfi_rs2_addr,
    output logic [31:0] rvfi_rs1_rdata,
    output logic [31:0] rvfi_rs2_rdata,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rd_wdata,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata,
    output logic [31:0] rvfi_mem_addr,
    output logic [3:0]  rvfi_mem_rmask,
    output logic [3:0]  rvfi_mem_wmask,
    output logic [31:0] rvfi_mem_rdata,
    output logic [31:0] rvfi_mem_wdata,
    output logic        err_load_timeout
);
    rvfi_gen_state_t        state;
    ret_record_t            hold, in_rec, src;
    logic [ORDER_WIDTH-1:0] order_cnt;
    logic                   intr_pending, accept, go_wait, emit_load, emit;
    logic [31:0]            rd_src, mem_rd_src;

    assign in_rec = '{insn: ret_insn, pc: ret_pc, next_pc: ret_next_pc, trap: ret_trap,
                      halt: ret_halt, irq_taken: ret_irq_taken, rs1_addr: ret_rs1_addr,
                      rs2_addr: ret_rs2_addr, rd_addr: ret_rd_addr, rs1_rdata: ret_rs1_rdata,
                      rs2_rdata: ret_rs2_rdata, rd_wdata: ret_rd_wdata, mem_addr: ret_mem_addr,
                      mem_wdata: ret_mem_wdata, mem_rmask: ret_mem_rmask, mem_wmask: ret_mem_wmask};

    assign ret_ready  = state == IDLE;
    assign accept     = ret_valid && ret_ready;
    assign go_wait    = accept && ret_is_load && !ret_trap;
    assign emit_load  = state == WAIT_LOAD && lsu_rvalid;
    assign emit       = (accept && !go_wait) || emit_load;
    assign src        = state == WAIT_LOAD ? hold : in_rec;
    assign rd_src     = state == WAIT_LOAD ? lsu_rd_wdata : ret_rd_wdata;
    assign mem_rd_src = state == WAIT_LOAD ? lsu_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            hold           <= '0;
            order_cnt      <= '0;
            intr_pending   <= 1'b0;
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_trap      <= 1'b0;
            rvfi_halt      <= 1'b0;
            rvfi_intr      <= 1'b0;
            rvfi_mode      <= PRIV_MODE;
            rvfi_ixl       <= RVFI_IXL_RV32;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else begin
            rvfi_valid <= emit;
            rvfi_mode  <= PRIV_MODE;
            rvfi_ixl   <= RVFI_IXL_RV32;
            if (go_wait) begin
                hold  <= in_rec;
                state <= WAIT_LOAD;
            end
            if (emit_load) state <= IDLE;
            if (emit) begin
                order_cnt      <= order_cnt + ORDER_WIDTH'(1);
                intr_pending   <= src.trap || src.irq_taken;
                rvfi_order     <= 64'(order_cnt);
                rvfi_intr      <= intr_pending;
                rvfi_insn      <= src.insn;
                rvfi_trap      <= src.trap;
                rvfi_halt      <= src.halt;
                rvfi_rs1_addr  <= src.rs1_addr;
                rvfi_rs2_addr  <= src.rs2_addr;
                rvfi_rs1_rdata <= src.rs1_rdata;
                rvfi_rs2_rdata <= src.rs2_rdata;
                rvfi_rd_addr   <= src.trap ? 5'd0 : src.rd_addr;
                rvfi_rd_wdata  <= (src.trap || src.rd_addr == 5'd0) ? 32'd0 : rd_src;
                rvfi_pc_rdata  <= src.pc;
                rvfi_pc_wdata  <= src.next_pc;
                rvfi_mem_addr  <= src.mem_addr;
                rvfi_mem_rmask <= src.trap ? 4'd0 : src.mem_rmask;
                rvfi_mem_wmask <= src.trap ? 4'd0 : src.mem_wmask;
                rvfi_mem_rdata <= mem_rd_src;
                rvfi_mem_wdata <= src.mem_wdata;
            end
        end
    end

`ifdef RVFI_GEN_WATCHDOG_EN
    rvfi_load_watchdog #(.CYCLES(WATCHDOG_CYCLES)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .start  (go_wait),
        .active (state == WAIT_LOAD && !lsu_rvalid),
        .err    (err_load_timeout)
    );
`else
    assign err_load_timeout = WATCHDOG_CYCLES < 0;
`endif
endmodule

// File: tb/tb_rvfi_generator.sv
// tb_rvfi_generator: directed self-checking bench for rvfi_generator
module tb_rvfi_generator;
    logic        clk = 1'b0;
    logic        reset;
    logic        ret_valid, ret_ready, ret_trap, ret_halt, ret_irq_taken, ret_is_load;
    logic [31:0] ret_insn, ret_pc, ret_next_pc, ret_rs1_rdata, ret_rs2_rdata, ret_rd_wdata;
    logic [4:0]  ret_rs1_addr, ret_rs2_addr, ret_rd_addr;
    logic [31:0] ret_mem_addr, ret_mem_wdata;
    logic [3:0]  ret_mem_rmask, ret_mem_wmask;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata, lsu_rd_wdata;
    logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata;
    logic [31:0] rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [1:0]  rvfi_mode, rvfi_ixl;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        err_load_timeout;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    rvfi_generator #(.WATCHDOG_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_ready(ret_ready),
        .ret_insn(ret_insn), .ret_pc(ret_pc), .ret_next_pc(ret_next_pc),
        .ret_trap(ret_trap), .ret_halt(ret_halt), .ret_irq_taken(ret_irq_taken),
        .ret_rs1_addr(ret_rs1_addr), .ret_rs2_addr(ret_rs2_addr), .ret_rd_addr(ret_rd_addr),
        .ret_rs1_rdata(ret_rs1_rdata), .ret_rs2_rdata(ret_rs2_rdata), .ret_rd_wdata(ret_rd_wdata),
        .ret_is_load(ret_is_load), .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata),
        .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rd_wdata(lsu_rd_wdata),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .err_load_timeout(err_load_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [4:0] rd, input logic [31:0] wdata, input logic [31:0] pc);
        ret_rd_addr   = rd;
        ret_rd_wdata  = wdata;
        ret_pc        = pc;
        ret_next_pc   = pc + 32'd4;
        ret_insn      = 32'h0020_8033 | {20'd0, rd, 7'd0};
        ret_rs1_addr  = 5'd1;
        ret_rs2_addr  = 5'd2;
        ret_rs1_rdata = 32'd3;
        ret_rs2_rdata = 32'd4;
        ret_mem_addr  = 32'd0;
        ret_mem_wdata = 32'd0;
        ret_mem_rmask = 4'd0;
        ret_mem_wmask = 4'd0;
    endtask

    initial begin
        reset = 1'b1;
        {ret_valid, ret_trap, ret_halt, ret_irq_taken, ret_is_load, lsu_rvalid} = '0;
        lsu_rdata = '0;
        lsu_rd_wdata = '0;
        set_rec(5'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rst_valid", rvfi_valid, 0);
        chk("rst_order", rvfi_order, 0);
        chk("rst_mode", rvfi_mode, 2'b11);
        chk("rst_ixl", rvfi_ixl, 2'b01);
        chk("rst_ready", ret_ready, 1);
        chk("rst_err", err_load_timeout, 0);
        chk("rst_rd_wdata", rvfi_rd_wdata, 0);
        reset = 1'b0;
        set_rec(5'd5, 32'h7, 32'h100);
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        chk("add_valid", rvfi_valid, 1);
        chk("add_order", rvfi_order, 0);
        chk("add_rd_wdata", rvfi_rd_wdata, 32'h7);
        chk("add_rd_addr", rvfi_rd_addr, 5);
        chk("add_pc_rdata", rvfi_pc_rdata, 32'h100);
        chk("add_pc_wdata", rvfi_pc_wdata, 32'h104);
        chk("add_insn", rvfi_insn, 32'h0020_82b3);
        chk("add_mem_rdata", rvfi_mem_rdata, 0);
        tick();
        chk("pulse_low", rvfi_valid, 0);
        set_rec(5'd6, 32'h999, 32'h104);
        ret_is_load = 1'b1;
        ret_mem_addr = 32'h2000;
        ret_mem_rmask = 4'hF;
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        ret_is_load = 1'b0;
        chk("lw_ready_c1", ret_ready, 0);
        chk("lw_valid_c1", rvfi_valid, 0);
        tick();
        chk("lw_ready_c2", ret_ready, 0);
        set_rec(5'd0, 32'h55, 32'h108);
        ret_valid = 1'b1;
        tick();
        chk("lw_ready_c3", ret_ready, 0);
        chk("lw_valid_c3", rvfi_valid, 0);
        lsu_rvalid = 1'b1;
        lsu_rdata = 32'hDEAD_BEEF;
        lsu_rd_wdata = 32'hFFFF_BEEF;
        tick();
        lsu_rvalid = 1'b0;
        chk("lw_valid", rvfi_valid, 1);
        chk("lw_order", rvfi_order, 1);
        chk("lw_mem_rdata", rvfi_mem_rdata, 32'hDEAD_BEEF);
        chk("lw_rd_wdata", rvfi_rd_wdata, 32'hFFFF_BEEF);
        chk("lw_rd_addr", rvfi_rd_addr, 6);
        chk("lw_pc_rdata", rvfi_pc_rdata, 32'h104);
        chk("lw_rmask", rvfi_mem_rmask, 4'hF);
        chk("lw_mem_addr", rvfi_mem_addr, 32'h2000);
        chk("lw_ready_back", ret_ready, 1);
        tick();
        ret_valid = 1'b0;
        chk("x0_valid", rvfi_valid, 1);
        chk("x0_order", rvfi_order, 2);
        chk("x0_rd_wdata", rvfi_rd_wdata, 0);
        chk("x0_pc_rdata", rvfi_pc_rdata, 32'h108);
        lsu_rvalid = 1'b1;
        tick();
        lsu_rvalid = 1'b0;
        chk("idle_lsu_ignored", rvfi_valid, 0);
        chk("idle_lsu_ready", ret_ready, 1);
        set_rec(5'd7, 32'h1234, 32'h10C);
        ret_trap = 1'b1;
        ret_mem_wmask = 4'hF;
        ret_mem_rmask = 4'hF;
        ret_valid = 1'b1;
        tick();
        chk("ecall_trap", rvfi_trap, 1);
        chk("ecall_wmask", rvfi_mem_wmask, 0);
        chk("ecall_rmask", rvfi_mem_rmask, 0);
        chk("ecall_rd_addr", rvfi_rd_addr, 0);
        chk("ecall_rd_wdata", rvfi_rd_wdata, 0);
        chk("ecall_intr", rvfi_intr, 0);
        chk("ecall_order", rvfi_order, 3);
        ret_trap = 1'b0;
        set_rec(5'd5, 32'h9, 32'h200);
        tick();
        chk("after_trap_intr", rvfi_intr, 1);
        chk("after_trap_order", rvfi_order, 4);
        chk("after_trap_trap", rvfi_trap, 0);
        chk("after_trap_rd", rvfi_rd_wdata, 32'h9);
        set_rec(5'd5, 32'hA, 32'h204);
        tick();
        chk("third_intr", rvfi_intr, 0);
        chk("third_order", rvfi_order, 5);
        for (int i = 0; i < 4; i++) begin
            set_rec(5'(i + 1), 32'h10 + 32'(i), 32'h300 + 32'(4 * i));
            tick();
            chk("b2b_valid", rvfi_valid, 1);
            chk("b2b_order", rvfi_order, 64'(6 + i));
            chk("b2b_rd_wdata", rvfi_rd_wdata, 64'(32'h10 + i));
        end
        set_rec(5'd3, 32'h20, 32'h400);
        ret_irq_taken = 1'b1;
        tick();
        ret_irq_taken = 1'b0;
        chk("irq_order", rvfi_order, 10);
        chk("irq_intr", rvfi_intr, 0);
        set_rec(5'd3, 32'h21, 32'h404);
        tick();
        chk("irq_next_intr", rvfi_intr, 1);
        chk("irq_next_order", rvfi_order, 11);
        set_rec(5'd8, 32'h77, 32'h500);
        ret_is_load = 1'b1;
        ret_trap = 1'b1;
        tick();
        ret_valid = 1'b0;
        ret_is_load = 1'b0;
        ret_trap = 1'b0;
        chk("trapload_valid", rvfi_valid, 1);
        chk("trapload_order", rvfi_order, 12);
        chk("trapload_ready", ret_ready, 1);
        chk("trapload_rd_addr", rvfi_rd_addr, 0);
        tick();
        chk("idle_valid", rvfi_valid, 0);
        set_rec(5'd9, 32'h0, 32'h600);
        ret_is_load = 1'b1;
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        ret_is_load = 1'b0;
        chk("rstw_ready", ret_ready, 0);
        reset = 1'b1;
        lsu_rvalid = 1'b1;
        tick();
        reset = 1'b0;
        lsu_rvalid = 1'b0;
        chk("rstw_valid", rvfi_valid, 0);
        chk("rstw_ready_after", ret_ready, 1);
        tick();
        chk("rstw_no_emit", rvfi_valid, 0);
        set_rec(5'd5, 32'h3, 32'h700);
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        chk("rstw_next_order", rvfi_order, 0);
        chk("rstw_next_valid", rvfi_valid, 1);
        chk("rstw_next_intr", rvfi_intr, 0);
`ifdef RVFI_GEN_WATCHDOG_EN
        set_rec(5'd6, 32'h0, 32'h800);
        ret_is_load = 1'b1;
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        ret_is_load = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("wd_err_early", err_load_timeout, 0);
        end
        tick();
        chk("wd_err_set", err_load_timeout, 1);
        chk("wd_still_wait", ret_ready, 0);
        lsu_rvalid = 1'b1;
        lsu_rdata = 32'hCAFE_0001;
        lsu_rd_wdata = 32'hCAFE_0001;
        tick();
        lsu_rvalid = 1'b0;
        chk("wd_late_valid", rvfi_valid, 1);
        chk("wd_late_order", rvfi_order, 1);
        chk("wd_late_rdata", rvfi_mem_rdata, 32'hCAFE_0001);
        chk("wd_err_sticky", err_load_timeout, 1);
`else
        chk("err_tied_low", err_load_timeout, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
